axi_read_splitter: RTL

//  AXI4 read-channel splitter placed upstream of the AXI register/interconnect/RAM chain.

---
 rtl/axi_read_splitter_if.sv | 45 ++++
 rtl/axi_read_splitter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axi_read_splitter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the upstream and downstream
// sides of the read splitter. The master drives AR and accepts R; the slave
// accepts AR and drives R.
interface axi_read_splitter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int ARUSER_WIDTH = 8,
  parameter int RUSER_WIDTH  = 8
);
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [RUSER_WIDTH-1:0]  ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_read_splitter.sv
// AXI4 read splitter: takes one AR request of up to 256 beats and replays it
// downstream as INCR sub-bursts of at most MAX_BURST_LEN beats that never
// cross a 4 KB page. R beats flow straight through with zero latency; RLAST
// is only passed upstream on the final beat of the final sub-burst.
// FIXED and WRAP requests are forwarded as a single unchanged sub-burst.
module axi_read_splitter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter int ARUSER_WIDTH  = 8,
  parameter int RUSER_WIDTH   = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  axi_read_splitter_if.slave  s_axi,
  axi_read_splitter_if.master m_axi
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [1:0]            BURST_INCR = 2'b01;
  localparam logic [12:0]           MAX_BEATS  = 13'(MAX_BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;

  // Latched copy of the original request
  logic [ID_WIDTH-1:0]     id_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    lock_q;
  logic [3:0]              cache_q;
  logic [2:0]              prot_q;
  logic [3:0]              qos_q;
  logic [ARUSER_WIDTH-1:0] user_q;

  // Split progress
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [8:0]              remaining;
  logic [8:0]              beats_q;
  logic                    first_sub;
  logic                    last_sub;

  // Registered downstream AR request
  logic                    arvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;

  // Sub-burst sizing
  logic [ADDR_WIDTH-1:0]   size_mask;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic [12:0]             page_bytes;
  logic [12:0]             page_beats;
  logic [12:0]             beats_calc;
  logic [8:0]              beats_next;

  // R payload taps, sized by the block's own data/user widths
  logic [DATA_WIDTH-1:0]   r_data;
  logic [RUSER_WIDTH-1:0]  r_user;

  // Size of the next sub-burst: limited by what is left, the burst cap and the 4 KB page
  always_comb begin
    size_mask    = (ADDR_ONE << size_q) - ADDR_ONE;
    aligned_addr = cur_addr & ~size_mask;
    page_bytes   = 13'h1000 - {1'b0, aligned_addr[11:0]};
    page_beats   = page_bytes >> size_q;
    beats_calc   = {4'b0000, remaining};
    beats_calc   = (MAX_BEATS < beats_calc) ? MAX_BEATS : beats_calc;
    beats_calc   = (page_beats < beats_calc) ? page_beats : beats_calc;
    if (burst_q == BURST_INCR) begin
      beats_next = beats_calc[8:0];
    end else begin
      beats_next = remaining;
    end
  end

  // Control FSM: capture request, issue sub-bursts one at a time, track the data phase
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id_q      <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      lock_q    <= 1'b0;
      cache_q   <= 4'd0;
      prot_q    <= 3'd0;
      qos_q     <= 4'd0;
      user_q    <= '0;
      cur_addr  <= '0;
      remaining <= 9'd0;
      beats_q   <= 9'd0;
      first_sub <= 1'b0;
      last_sub  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi.arvalid) begin
            id_q      <= s_axi.arid;
            len_q     <= s_axi.arlen;
            size_q    <= s_axi.arsize;
            burst_q   <= s_axi.arburst;
            lock_q    <= s_axi.arlock;
            cache_q   <= s_axi.arcache;
            prot_q    <= s_axi.arprot;
            qos_q     <= s_axi.arqos;
            user_q    <= s_axi.aruser;
            cur_addr  <= s_axi.araddr;
            remaining <= {1'b0, s_axi.arlen} + 9'd1;
            first_sub <= 1'b1;
            last_sub  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!arvalid_q) begin
            // Only the first INCR sub-burst keeps the caller's unaligned address
            araddr_q  <= (first_sub || (burst_q != BURST_INCR)) ? cur_addr : aligned_addr;
            arlen_q   <= (burst_q == BURST_INCR) ? 8'(beats_next - 9'd1) : len_q;
            beats_q   <= beats_next;
            arvalid_q <= 1'b1;
          end else if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            cur_addr  <= aligned_addr + (ADDR_WIDTH'(beats_q) << size_q);
            remaining <= remaining - beats_q;
            last_sub  <= (remaining == beats_q);
            first_sub <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (m_axi.rvalid && s_axi.rready && m_axi.rlast) begin
            state <= (remaining != 9'd0) ? ISSUE : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Upstream AR: accept only when idle and out of reset
  assign s_axi.arready = (state == IDLE) && !rst;

  // Downstream AR: registered payload, valid forced low during reset
  assign m_axi.arid    = id_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = burst_q;
  assign m_axi.arlock  = lock_q;
  assign m_axi.arcache = cache_q;
  assign m_axi.arprot  = prot_q;
  assign m_axi.arqos   = qos_q;
  assign m_axi.aruser  = user_q;
  assign m_axi.arvalid = arvalid_q && !rst;

  // R passthrough, open only in the data phase
  assign r_data        = m_axi.rdata;
  assign r_user        = m_axi.ruser;
  assign s_axi.rid     = m_axi.rid;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = m_axi.rresp;
  assign s_axi.ruser   = r_user;
  assign s_axi.rlast   = m_axi.rlast && last_sub;
  assign s_axi.rvalid  = m_axi.rvalid && (state == DATA) && !rst;
  assign m_axi.rready  = s_axi.rready && (state == DATA) && !rst;

endmodule
